rotate_sequencer: RTL and testbench

ROTATE_SEQUENCER -- requirements
Module: rotate_sequencer

---
 rtl/rotate_pkg.sv | 52 +++++
 rtl/debouncer.sv | 69 ++++++
 rtl/rotate_sequencer.sv | 143 ++++++++++++++
 tb/tb_rotate_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rotate_pkg
//  Description : Shared types, default constants and rotation helpers for the
//                rotate_sequencer block (FSM state, rotation direction).
//  Revision    : 1.0 - initial release
// ============================================================================
package rotate_pkg;

    // Operating mode of the sequencer.
    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    // Direction of the most recent rotation; also used by automatic stepping.
    typedef enum logic [0:0] {
        RIGHT = 1'b0,
        LEFT  = 1'b1
    } dir_t;

    localparam int c_default_debounce_cycles = 1_000_000;
    localparam int c_default_auto_period     = 50_000_000;

    // Circular rotation of the 16-bit pattern by one or two places.
    function automatic logic [15:0] rotate16(
        input logic [15:0] v,
        input dir_t        d,
        input logic        step2
    );
        logic [15:0] r;
        if (d == RIGHT) begin
            r = step2 ? {v[1:0], v[15:2]} : {v[0], v[15:1]};
        end else begin
            r = step2 ? {v[13:0], v[15:14]} : {v[14:0], v[15]};
        end
        return r;
    endfunction

    // Position tracks net rotation modulo 16: right adds, left subtracts.
    function automatic logic [3:0] next_pos(
        input logic [3:0] p,
        input dir_t       d,
        input logic       step2
    );
        logic [3:0] s;
        s = step2 ? 4'd2 : 4'd1;
        return (d == RIGHT) ? (p + s) : (p - s);
    endfunction

endpackage : rotate_pkg
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer
//  Description : Two-flop synchronizer, consecutive-sample debounce counter and
//                rising-edge press pulse for one raw push button.
//  Ports       : clk      - system clock
//                rst_n    - synchronous active-low reset
//                btn_raw  - asynchronous raw button input
//                level    - debounced button level
//                press    - one-cycle pulse on a debounced 0->1 transition
//  Revision    : 1.0 - initial release
// ============================================================================
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic [2:0]         r_arm;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_press;

    // r_arm fills with ones after reset; r_sync[1] carries a real sample once
    // r_arm[1] is set. On that first real sample the level is adopted without
    // a pulse, so a button held across reset release never produces an event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_arm   <= 3'b000;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_raw};
            r_arm   <= {r_arm[1:0], 1'b1};
            r_press <= 1'b0;
            if (r_arm[1] && !r_arm[2]) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else if (r_arm[2]) begin
                if (r_sync[1] != r_level) begin
                    if (r_cnt == c_cnt_last) begin
                        r_level <= r_sync[1];
                        r_press <= r_sync[1];
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule : debouncer
`default_nettype wire

// File: rtl/rotate_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rotate_sequencer
//  Description : 16-bit circular pattern rotator driven by debounced buttons,
//                with a manual mode and an automatic periodic-rotation mode.
//  Ports       : clk     - system clock
//                rst_n   - synchronous active-low reset
//                sw      - pattern load value
//                BTNR    - raw button, rotate right
//                BTNL    - raw button, rotate left
//                BTNC    - raw button, held level selects 2-bit step
//                BTNU    - raw button, load sw into pattern
//                BTND    - raw button, toggle automatic mode
//                led     - current pattern
//                pos     - net rotation position mod 16 since last load
//                auto_on - high while in automatic mode
//  Revision    : 1.0 - initial release
// ============================================================================
module rotate_sequencer
    import rotate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles,
    parameter int AUTO_PERIOD     = c_default_auto_period
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sw,
    input  logic        BTNR,
    input  logic        BTNL,
    input  logic        BTNC,
    input  logic        BTNU,
    input  logic        BTND,
    output logic [15:0] led,
    output logic [3:0]  pos,
    output logic        auto_on
);

    localparam int c_idx_r  = 0;
    localparam int c_idx_l  = 1;
    localparam int c_idx_c  = 2;
    localparam int c_idx_u  = 3;
    localparam int c_idx_d  = 4;
    localparam int c_nbtn   = 5;

    localparam int c_presc_w = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(AUTO_PERIOD - 1);

    logic [c_nbtn-1:0] w_raw;
    logic [c_nbtn-1:0] w_level;
    logic [c_nbtn-1:0] w_press;
    logic [3:0]        w_unused_levels;

    logic              w_step2;
    logic              w_load;
    logic              w_rot_r;
    logic              w_rot_l;
    logic              w_toggle;

    logic [15:0]          r_led;
    logic [3:0]           r_pos;
    dir_t                 r_dir;
    state_t               r_state;
    logic                 r_auto_on;
    logic [c_presc_w-1:0] r_presc;

    assign w_raw = {BTND, BTNU, BTNC, BTNL, BTNR};

    generate
        for (genvar gi = 0; gi < c_nbtn; gi++) begin : g_debounce
            debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debouncer (
                .clk     (clk),
                .rst_n   (rst_n),
                .btn_raw (w_raw[gi]),
                .level   (w_level[gi]),
                .press   (w_press[gi])
            );
        end
    endgenerate

    // Only the step-select button is used as a level; the rest act on presses.
    assign w_unused_levels = {w_level[c_idx_d], w_level[c_idx_u],
                              w_level[c_idx_l], w_level[c_idx_r]};

    assign w_step2  = w_level[c_idx_c];
    assign w_load   = w_press[c_idx_u];
    assign w_rot_r  = w_press[c_idx_r];
    assign w_rot_l  = w_press[c_idx_l];
    assign w_toggle = w_press[c_idx_d];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led     <= 16'h0000;
            r_pos     <= 4'd0;
            r_dir     <= RIGHT;
            r_state   <= MANUAL;
            r_auto_on <= 1'b0;
            r_presc   <= '0;
        end else begin
            // Load beats rotation; opposing simultaneous rotations cancel and
            // fall through to the automatic-step path.
            if (w_load) begin
                r_led   <= sw;
                r_pos   <= 4'd0;
                r_presc <= '0;
            end else if (w_rot_r ^ w_rot_l) begin
                if (w_rot_r) begin
                    r_led <= rotate16(r_led, RIGHT, w_step2);
                    r_pos <= next_pos(r_pos, RIGHT, w_step2);
                    r_dir <= RIGHT;
                end else begin
                    r_led <= rotate16(r_led, LEFT, w_step2);
                    r_pos <= next_pos(r_pos, LEFT, w_step2);
                    r_dir <= LEFT;
                end
                r_presc <= '0;
            end else if (r_state == AUTO) begin
                if (r_presc == c_presc_last) begin
                    r_presc <= '0;
                    r_led   <= rotate16(r_led, r_dir, w_step2);
                    r_pos   <= next_pos(r_pos, r_dir, w_step2);
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            // Mode toggle composes with whatever happened above; entering
            // either mode restarts the period.
            if (w_toggle) begin
                r_state   <= (r_state == AUTO) ? MANUAL : AUTO;
                r_auto_on <= (r_state == MANUAL);
                r_presc   <= '0;
            end
        end
    end

    assign led     = r_led;
    assign pos     = r_pos;
    assign auto_on = r_auto_on;

endmodule : rotate_sequencer
`default_nettype wire

// File: tb/tb_rotate_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rotate_sequencer
//  Description : Directed self-checking bench for rotate_sequencer with short
//                debounce (4) and auto period (8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rotate_sequencer;

    localparam int c_hold = 10;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw;
    logic [4:0]  btn;   // {D, U, C, L, R}
    logic [15:0] led;
    logic [3:0]  pos;
    logic        auto_on;

    int n_checks;
    int n_fail;

    rotate_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .AUTO_PERIOD     (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .BTNR    (btn[0]),
        .BTNL    (btn[1]),
        .BTNC    (btn[2]),
        .BTNU    (btn[3]),
        .BTND    (btn[4]),
        .led     (led),
        .pos     (pos),
        .auto_on (auto_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] mask);
        btn = btn | mask;
        wait_cycles(c_hold);
        btn = btn & ~mask;
        wait_cycles(c_hold);
    endtask

    task automatic load(input logic [15:0] v);
        sw = v;
        press(5'b01000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = 5'b00000;
        sw    = 16'h0000;
        wait_cycles(3);
        n_checks++;
        if (led !== 16'h0000) begin n_fail++; $display("FAIL reset_led: got %h want 0000", led); end
        n_checks++;
        if (pos !== 4'd0) begin n_fail++; $display("FAIL reset_pos: got %0d want 0", pos); end
        n_checks++;
        if (auto_on !== 1'b0) begin n_fail++; $display("FAIL reset_auto: got %b want 0", auto_on); end
        rst_n = 1'b1;
        wait_cycles(5);
    endtask

    task automatic test_load_rotate();
        load(16'h8001);
        n_checks++;
        if (led !== 16'h8001) begin n_fail++; $display("FAIL load_led: got %h want 8001", led); end
        press(5'b00001);
        n_checks++;
        if (led !== 16'hC000) begin n_fail++; $display("FAIL right1_led: got %h want c000", led); end
        n_checks++;
        if (pos !== 4'd1) begin n_fail++; $display("FAIL right1_pos: got %0d want 1", pos); end
    endtask

    task automatic test_left_step2_and_both();
        load(16'h0001);
        n_checks++;
        if (pos !== 4'd0) begin n_fail++; $display("FAIL load_pos: got %0d want 0", pos); end
        btn[2] = 1'b1;
        wait_cycles(c_hold);
        press(5'b00010);
        n_checks++;
        if (led !== 16'h0004) begin n_fail++; $display("FAIL left2_led: got %h want 0004", led); end
        n_checks++;
        if (pos !== 4'd14) begin n_fail++; $display("FAIL left2_pos: got %0d want 14", pos); end
        press(5'b00011);
        n_checks++;
        if (led !== 16'h0004) begin n_fail++; $display("FAIL both_led: got %h want 0004", led); end
        n_checks++;
        if (pos !== 4'd14) begin n_fail++; $display("FAIL both_pos: got %0d want 14", pos); end
        btn[2] = 1'b0;
        wait_cycles(c_hold);
    endtask

    task automatic test_glitch();
        btn[0] = 1'b1;
        wait_cycles(3);
        btn[0] = 1'b0;
        wait_cycles(c_hold);
        n_checks++;
        if (led !== 16'h0004) begin n_fail++; $display("FAIL glitch_led: got %h want 0004", led); end
        btn[0] = 1'b1;
        wait_cycles(c_hold);
        n_checks++;
        if (led !== 16'h0002) begin n_fail++; $display("FAIL held_led: got %h want 0002", led); end
        n_checks++;
        if (pos !== 4'd15) begin n_fail++; $display("FAIL held_pos: got %0d want 15", pos); end
        btn[0] = 1'b0;
        wait_cycles(c_hold);
        n_checks++;
        if (led !== 16'h0002) begin n_fail++; $display("FAIL release_led: got %h want 0002", led); end
    endtask

    task automatic test_wrap();
        btn[2] = 1'b1;
        wait_cycles(c_hold);
        press(5'b00001);
        n_checks++;
        if (led !== 16'h8000) begin n_fail++; $display("FAIL wrap_r2_led: got %h want 8000", led); end
        n_checks++;
        if (pos !== 4'd1) begin n_fail++; $display("FAIL wrap_r2_pos: got %0d want 1", pos); end
        press(5'b00010);
        n_checks++;
        if (led !== 16'h0002) begin n_fail++; $display("FAIL wrap_l2_led: got %h want 0002", led); end
        n_checks++;
        if (pos !== 4'd15) begin n_fail++; $display("FAIL wrap_l2_pos: got %0d want 15", pos); end
        btn[2] = 1'b0;
        wait_cycles(c_hold);
        press(5'b00001);
        n_checks++;
        if (led !== 16'h0001) begin n_fail++; $display("FAIL wrap_r1_led: got %h want 0001", led); end
        n_checks++;
        if (pos !== 4'd0) begin n_fail++; $display("FAIL wrap_r1_pos: got %0d want 0", pos); end
    endtask

    task automatic test_auto();
        logic [15:0] exp_led;
        logic [3:0]  exp_pos;
        int          cyc;
        bit          seen;
        btn[4] = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (auto_on === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (auto_on !== 1'b1) begin n_fail++; $display("FAIL auto_enter: got %b want 1", auto_on); end
        btn[4]  = 1'b0;
        exp_led = 16'h0001;
        exp_pos = 4'd0;
        for (int s = 0; s < 16; s++) begin
            cyc  = 0;
            seen = 1'b0;
            while (!seen && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (led !== exp_led) seen = 1'b1;
            end
            exp_led = {exp_led[0], exp_led[15:1]};
            exp_pos = exp_pos + 4'd1;
            n_checks++;
            if (led !== exp_led) begin n_fail++; $display("FAIL auto_led step %0d: got %h want %h", s, led, exp_led); end
            n_checks++;
            if (cyc != 8) begin n_fail++; $display("FAIL auto_period step %0d: got %0d want 8", s, cyc); end
            n_checks++;
            if (pos !== exp_pos) begin n_fail++; $display("FAIL auto_pos step %0d: got %0d want %0d", s, pos, exp_pos); end
        end
        n_checks++;
        if (pos !== 4'd0) begin n_fail++; $display("FAIL auto_pos_return: got %0d want 0", pos); end
        press(5'b10000);
        n_checks++;
        if (auto_on !== 1'b0) begin n_fail++; $display("FAIL auto_exit: got %b want 0", auto_on); end
    endtask

    task automatic test_reset_mid_auto();
        load(16'h00F0);
        press(5'b10000);
        n_checks++;
        if (auto_on !== 1'b1) begin n_fail++; $display("FAIL auto_reenter: got %b want 1", auto_on); end
        btn[0] = 1'b1;
        wait_cycles(3);
        rst_n = 1'b0;
        wait_cycles(2);
        n_checks++;
        if (led !== 16'h0000) begin n_fail++; $display("FAIL midrst_led: got %h want 0000", led); end
        n_checks++;
        if (pos !== 4'd0) begin n_fail++; $display("FAIL midrst_pos: got %0d want 0", pos); end
        n_checks++;
        if (auto_on !== 1'b0) begin n_fail++; $display("FAIL midrst_auto: got %b want 0", auto_on); end
        rst_n = 1'b1;
        wait_cycles(20);
        n_checks++;
        if (pos !== 4'd0) begin n_fail++; $display("FAIL held_after_rst_pos: got %0d want 0", pos); end
        n_checks++;
        if (auto_on !== 1'b0) begin n_fail++; $display("FAIL held_after_rst_auto: got %b want 0", auto_on); end
        btn[0] = 1'b0;
        wait_cycles(c_hold);
        n_checks++;
        if (pos !== 4'd0) begin n_fail++; $display("FAIL release_after_rst_pos: got %0d want 0", pos); end
        press(5'b00001);
        n_checks++;
        if (pos !== 4'd1) begin n_fail++; $display("FAIL press_after_rst_pos: got %0d want 1", pos); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        btn      = 5'b00000;
        sw       = 16'h0000;
        test_reset();
        test_load_rotate();
        test_left_step2_and_both();
        test_glitch();
        test_wrap();
        test_auto();
        test_reset_mid_auto();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rotate_sequencer
`default_nettype wire
